// File: rtl/mp_add_seq.sv
// -----------------------------------------------------------------------------
// mp_add_seq -- multi-precision add/subtract sequencer.
//
// Takes two WORDS x 16-bit operands on a valid/ready handshake and pushes them
// through a single 16-bit carry-lookahead adder (cla16), least significant
// slice first. Each slice's registered carry-out feeds the next slice's
// carry-in. The full-width result comes back on a second valid/ready
// handshake. Subtract is A + ~B + 1: B is inverted when the operands are
// captured, and the carry register is seeded with 1.
//
// Parameters:
//   WORDS      number of 16-bit slices per operand (2..16)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand request valid
//   in_ready   operands accepted (high only in IDLE)
//   op_a/op_b  operands, 16*WORDS bits
//   sub        0 = A+B, 1 = A-B
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   sum        registered result, modulo 2^(16*WORDS)
//   carry_out  carry out of the top slice (subtract: 1 = no borrow)
//   overflow   signed overflow of the top slice (only with MP_ADD_SEQ_OVF_EN)
//
// Optional feature macro: MP_ADD_SEQ_OVF_EN adds the overflow output.
// -----------------------------------------------------------------------------

// 16-bit carry-lookahead adder: four 4-bit groups with full lookahead both
// inside each group and across the groups.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co,
    output logic        gg,
    output logic        pg
);
    logic [15:0] g, p, c;
    logic [3:0]  grp_g, grp_p;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign grp_g[k] = g[4*k+3]
                        | (p[4*k+3] & g[4*k+2])
                        | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                        | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        assign grp_p[k] = &p[4*k +: 4];
    end

    // Group carries expanded from ci so no carry depends on another carry bit.
    assign gc[0] = ci;
    assign gc[1] = grp_g[0] | (grp_p[0] & ci);
    assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & ci);
    assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & ci);
    assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & ci);

    for (genvar k = 0; k < 4; k++) begin : g_bit
        assign c[4*k]   = gc[k];
        assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
        assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
        assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                        | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    assign s  = p ^ c;
    assign co = gc[4];
    assign gg = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    assign pg = &grp_p;
endmodule

module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                carry_out
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    output logic                overflow
`endif
);
    localparam int W    = 16 * WORDS;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;     // holds ~op_b for subtract
    logic            sub_q, sub_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
`ifdef MP_ADD_SEQ_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [15:0] slice_a, slice_b, slice_s;
    logic        slice_co, slice_gg, slice_pg;

    assign slice_a = a_q[16*idx_q +: 16];
    assign slice_b = b_q[16*idx_q +: 16];

    cla16 u_cla (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .gg (slice_gg),
        .pg (slice_pg)
    );

    // Group outputs and the latched op flag are not needed by the datapath.
    logic unused_sig;
    assign unused_sig = slice_gg ^ slice_pg ^ sub_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef MP_ADD_SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    sub_d   = sub;
                    carry_d = sub;    // the +1 of A + ~B + 1
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[16*idx_q +: 16] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = slice_co;
`ifdef MP_ADD_SEQ_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[15] != a_q[W-1]);
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef MP_ADD_SEQ_OVF_EN
    assign overflow  = ovf_q;
`endif
endmodule
